piso_serializer_32: RTL and testbench
=====================================

PISO_SERIALIZER_32 -- requirements
Module: piso_serializer_32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the word length in bits (legal range 2..64).
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0, giving the Serial_Data_Out level when no frame is active.
REQ-003 SHALL have port Clk_In  input  1  clock; all state updates on posedge.
REQ-004 SHALL have port Reset_In  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Parallel_Data_In  input  DATA_WIDTH  word to serialize, sampled only on load acceptance.
REQ-006 SHALL have port Load_Valid_In  input  1  requester has a word on Parallel_Data_In.
REQ-007 SHALL have port Load_Ready_Out  output  1  block can accept a word this cycle (combinational from state/count).
REQ-008 SHALL have port Serial_Data_Out  output  1  serial bit, registered, LSB first.
REQ-009 SHALL have port Serial_Valid_Out  output  1  Serial_Data_Out carries a frame bit this cycle, registered.
REQ-010 SHALL have port Busy_Out  output  1  frame in progress, registered.
REQ-011 SHALL have port Frame_Done_Out  output  1  one-cycle pulse, high while the last bit of a frame is presented.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT plus a bit counter of width $clog2(DATA_WIDTH), range 0..DATA_WIDTH-1.
REQ-013 SHALL accept a word on a posedge where Load_Valid_In and Load_Ready_Out are both 1, capturing Parallel_Data_In into the shift register.
REQ-014 SHALL drive Load_Ready_Out = 1 in IDLE, and in SHIFT only when counter = DATA_WIDTH-1; 0 otherwise.
REQ-015 SHALL present bit k of the accepted word on Serial_Data_Out in the k-th cycle after acceptance (k = 0..DATA_WIDTH-1), i.e. first bit one cycle after the accepting edge.
REQ-016 SHALL hold Serial_Valid_Out = 1 and Busy_Out = 1 for exactly DATA_WIDTH cycles per frame; bits are stable for a full cycle so a receiver on the same clock samples them on negedge.
REQ-017 SHALL assert Frame_Done_Out in the cycle where counter = DATA_WIDTH-1, for exactly one cycle per frame.
REQ-018 On acceptance at the last-bit edge (back-to-back), SHALL start the new frame with no gap: Serial_Valid_Out stays 1, counter wraps to 0.
REQ-019 Without a new acceptance at the last-bit edge, SHALL return to IDLE: Serial_Valid_Out = 0, Busy_Out = 0, Serial_Data_Out = IDLE_LEVEL.
REQ-020 SHALL ignore Load_Valid_In while Load_Ready_Out = 0; the requester must hold its word until accepted.
REQ-021 SHALL ignore changes on Parallel_Data_In after acceptance; the transmitted frame equals the captured word exactly.

Reset
REQ-022 On Reset_In = 1, SHALL immediately (no clock needed) force state IDLE, counter 0, shift register 0, Serial_Data_Out = IDLE_LEVEL, Serial_Valid_Out = 0, Busy_Out = 0, Frame_Done_Out = 0.
REQ-023 Reset mid-frame SHALL abort the frame with no Frame_Done_Out pulse; the first acceptance after reset release starts at bit 0.
REQ-024 While Reset_In = 1, Load_Ready_Out SHALL be 0 and no word SHALL be accepted.

Structure
REQ-025 The state encoding (IDLE, SHIFT) and the DATA_WIDTH default constant SHALL live in shared package shift_register_pkg.
REQ-026 The bit counter with wrap and last-bit flag SHALL be sub-module piso_bit_counter; the FSM and shift register stay in the top level.

Verification
REQ-027 Load 32'hA5A5_0F01 from IDLE -> serial bits 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,... over 32 cycles; Frame_Done_Out in cycle 32; a negedge-sampling receiver gated by Serial_Valid_Out reassembles 32'hA5A5_0F01.
REQ-028 Back-to-back 32'hFFFF_FFFF then 32'h0000_0001 -> Serial_Valid_Out high for 64 consecutive cycles; Frame_Done_Out pulses at cycles 32 and 64; bit 32 of the stream is 1, bits 33..63 are 0.
REQ-029 Load_Valid_In raised with 32'h1234_5678 at cycle 10 of a frame -> not accepted until Load_Ready_Out rises at cycle 32; second frame is 32'h1234_5678 unmodified.
REQ-030 Reset_In pulsed asynchronously mid-cycle at bit 15 -> outputs go to reset values before the next edge, no Frame_Done_Out; the next load of 32'h0000_0003 emits 1,1,0,... from bit 0.
REQ-031 Parallel_Data_In toggled every cycle after accepting 32'hDEAD_BEEF -> serial stream still equals 32'hDEAD_BEEF.
REQ-032 IDLE_LEVEL = 1, DATA_WIDTH = 8, load 8'h00 -> line 1 in IDLE, 8 zero bits, line back to 1.

Source files
------------

// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Shared definitions for the parallel-in / serial-out serializer:
//   - DATA_WIDTH_DEFAULT : default word length in bits
//   - fsm_state_e        : serializer FSM state encoding (IDLE, SHIFT)
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } fsm_state_e;

endpackage : shift_register_pkg

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// Index of the bit currently presented on the serial line.
// Ports:
//   Clk_In      in  clock, posedge
//   Reset_In    in  asynchronous active-high reset (count -> 0)
//   clear_in    in  a new word is being loaded; restart at bit 0
//   advance_in  in  a frame is in progress; step to the next bit
//   count_out   out current bit index, 0..DATA_WIDTH-1
//   last_out    out count_out is DATA_WIDTH-1 (last bit of the frame)
// -----------------------------------------------------------------------------
module piso_bit_counter
    import shift_register_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic                          clear_in,
    input  logic                          advance_in,
    output logic [$clog2(DATA_WIDTH)-1:0] count_out,
    output logic                          last_out
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: a load has priority; advancing from the last bit wraps to 0.
    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = CNT_ZERO;
        end else if (advance_in) begin
            if (count_q == CNT_LAST) begin
                count_d = CNT_ZERO;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign last_out  = (count_q == CNT_LAST);

endmodule : piso_bit_counter

// File: rtl/piso_serializer_32.sv
// -----------------------------------------------------------------------------
// piso_serializer_32
// Parallel-in / serial-out serializer, LSB first, with valid/ready load
// handshake and gap-free back-to-back frames.
// Ports:
//   Clk_In            in  clock, all state on posedge
//   Reset_In          in  asynchronous active-high reset
//   Parallel_Data_In  in  word to serialize, sampled only on acceptance
//   Load_Valid_In     in  requester presents a word
//   Load_Ready_Out    out a word can be accepted this cycle (combinational)
//   Serial_Data_Out   out serial bit (registered), IDLE_LEVEL between frames
//   Serial_Valid_Out  out Serial_Data_Out carries a frame bit (registered)
//   Busy_Out          out frame in progress (registered)
//   Frame_Done_Out    out high while the last bit of a frame is presented
// -----------------------------------------------------------------------------
module piso_serializer_32
    import shift_register_pkg::*;
#(
    parameter int   DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Busy_Out,
    output logic                  Frame_Done_Out
);

    localparam int CW = $clog2(DATA_WIDTH);
    // Done is registered, so it is raised on the edge leaving the
    // second-to-last bit.
    localparam logic [CW-1:0]         CNT_PRELAST = CW'(DATA_WIDTH - 2);
    localparam logic [DATA_WIDTH-1:0] SHIFT_ZERO  = {DATA_WIDTH{1'b0}};

    fsm_state_e            state_q;
    fsm_state_e            state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  serial_data_q;
    logic                  serial_data_d;
    logic                  serial_valid_q;
    logic                  serial_valid_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  frame_done_q;
    logic                  frame_done_d;

    logic [CW-1:0]         count_s;
    logic                  last_s;
    logic                  load_ready_s;
    logic                  accept_s;
    logic                  advance_s;

    piso_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .Clk_In     (Clk_In),
        .Reset_In   (Reset_In),
        .clear_in   (accept_s),
        .advance_in (advance_s),
        .count_out  (count_s),
        .last_out   (last_s)
    );

    // Ready in IDLE, or on the last bit so the next frame follows with no gap;
    // never while reset is asserted.
    always_comb begin
        load_ready_s = 1'b0;
        if (Reset_In) begin
            load_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = last_s;
        end
    end

    assign accept_s  = Load_Valid_In & load_ready_s;
    assign advance_s = (state_q == ST_SHIFT);

    // Next-state and next-output logic. The shift register holds the bits
    // not yet presented; bit 0 of an accepted word goes straight to the line.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        serial_data_d  = serial_data_q;
        serial_valid_d = serial_valid_q;
        busy_d         = busy_q;
        frame_done_d   = 1'b0;
        if (accept_s) begin
            state_d        = ST_SHIFT;
            shift_d        = {1'b0, Parallel_Data_In[DATA_WIDTH-1:1]};
            serial_data_d  = Parallel_Data_In[0];
            serial_valid_d = 1'b1;
            busy_d         = 1'b1;
            frame_done_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (last_s) begin
                        state_d        = ST_IDLE;
                        shift_d        = SHIFT_ZERO;
                        serial_data_d  = IDLE_LEVEL;
                        serial_valid_d = 1'b0;
                        busy_d         = 1'b0;
                        frame_done_d   = 1'b0;
                    end else begin
                        state_d        = ST_SHIFT;
                        shift_d        = {1'b0, shift_q[DATA_WIDTH-1:1]};
                        serial_data_d  = shift_q[0];
                        serial_valid_d = 1'b1;
                        busy_d         = 1'b1;
                        frame_done_d   = (count_s == CNT_PRELAST);
                    end
                end
                ST_IDLE: begin
                    state_d        = ST_IDLE;
                    shift_d        = shift_q;
                    serial_data_d  = IDLE_LEVEL;
                    serial_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    frame_done_d   = 1'b0;
                end
                default: begin
                    state_d        = ST_IDLE;
                    shift_d        = SHIFT_ZERO;
                    serial_data_d  = IDLE_LEVEL;
                    serial_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    frame_done_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM state, shift register and registered outputs; reset aborts a frame.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q        <= ST_IDLE;
            shift_q        <= SHIFT_ZERO;
            serial_data_q  <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            serial_data_q  <= serial_data_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign Load_Ready_Out   = load_ready_s;
    assign Serial_Data_Out  = serial_data_q;
    assign Serial_Valid_Out = serial_valid_q;
    assign Busy_Out         = busy_q;
    assign Frame_Done_Out   = frame_done_q;

endmodule : piso_serializer_32

// File: tb/tb_piso_serializer_32.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer_32
// Directed bench: a 32-bit instance (idle level 0) and an 8-bit instance
// (idle level 1). Outputs are sampled 1 time unit after each posedge; a
// negedge receiver reassembles the 32-bit stream LSB first.
// -----------------------------------------------------------------------------
module tb_piso_serializer_32;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        sdo;
    logic        svalid;
    logic        busy;
    logic        done;

    logic [7:0]  data8;
    logic        valid8;
    logic        ready8;
    logic        sdo8;
    logic        svalid8;
    logic        busy8;
    logic        done8;

    logic [31:0] rx_word;
    int          vectors;
    int          miscompares;

    piso_serializer_32 #(
        .DATA_WIDTH (32),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (data),
        .Load_Valid_In    (valid),
        .Load_Ready_Out   (ready),
        .Serial_Data_Out  (sdo),
        .Serial_Valid_Out (svalid),
        .Busy_Out         (busy),
        .Frame_Done_Out   (done)
    );

    piso_serializer_32 #(
        .DATA_WIDTH (8),
        .IDLE_LEVEL (1'b1)
    ) dut8 (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (data8),
        .Load_Valid_In    (valid8),
        .Load_Ready_Out   (ready8),
        .Serial_Data_Out  (sdo8),
        .Serial_Valid_Out (svalid8),
        .Busy_Out         (busy8),
        .Frame_Done_Out   (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same-clock receiver sampling mid-bit on negedge, LSB first.
    always @(negedge clk) begin
        if (svalid) begin
            rx_word <= {sdo, rx_word[31:1]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit k of word w must be on the line, framed, done/ready only on bit 31.
    task automatic check_bit(input string tag, input int k, input logic [31:0] w);
        chk($sformatf("%s sdo k=%0d", tag, k), 64'(sdo), 64'(w[k]));
        chk($sformatf("%s svalid k=%0d", tag, k), 64'(svalid), 64'(1'b1));
        chk($sformatf("%s busy k=%0d", tag, k), 64'(busy), 64'(1'b1));
        chk($sformatf("%s done k=%0d", tag, k), 64'(done), 64'(k == 31));
        chk($sformatf("%s ready k=%0d", tag, k), 64'(ready), 64'(k == 31));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle sdo"}, 64'(sdo), 64'(1'b0));
        chk({tag, " idle svalid"}, 64'(svalid), 64'(1'b0));
        chk({tag, " idle busy"}, 64'(busy), 64'(1'b0));
        chk({tag, " idle done"}, 64'(done), 64'(1'b0));
        chk({tag, " idle ready"}, 64'(ready), 64'(1'b1));
    endtask

    initial begin
        logic [31:0] w;
        vectors     = 0;
        miscompares = 0;
        rx_word     = 32'h0000_0000;
        rst    = 1'b1;
        data   = 32'h0000_0000;
        valid  = 1'b0;
        data8  = 8'h00;
        valid8 = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk("rst sdo", 64'(sdo), 64'(1'b0));
        chk("rst svalid", 64'(svalid), 64'(1'b0));
        chk("rst busy", 64'(busy), 64'(1'b0));
        chk("rst done", 64'(done), 64'(1'b0));
        chk("rst ready", 64'(ready), 64'(1'b0));
        chk("rst sdo8", 64'(sdo8), 64'(1'b1));
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle("post-rst");

        // Single frame A5A5_0F01 from IDLE.
        w = 32'hA5A5_0F01;
        data  = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            check_bit("a5", k, w);
            tick();
        end
        check_idle("a5");
        chk("a5 rx", 64'(rx_word), 64'(32'hA5A5_0F01));

        // Back-to-back FFFF_FFFF then 0000_0001: 64 valid cycles, no gap.
        data  = 32'hFFFF_FFFF;
        valid = 1'b1;
        tick();
        data  = 32'h0000_0001;
        for (int k = 0; k < 64; k++) begin
            if (k == 32) begin
                chk("b2b rx1", 64'(rx_word), 64'(32'hFFFF_FFFF));
                valid = 1'b0;
            end
            chk($sformatf("b2b sdo k=%0d", k), 64'(sdo), 64'((k < 32) || (k == 32)));
            chk($sformatf("b2b svalid k=%0d", k), 64'(svalid), 64'(1'b1));
            chk($sformatf("b2b done k=%0d", k), 64'(done), 64'((k == 31) || (k == 63)));
            tick();
        end
        check_idle("b2b");
        chk("b2b rx2", 64'(rx_word), 64'(32'h0000_0001));

        // Request raised at bit 10 waits until the last bit, word unmodified.
        w = 32'h0F0F_3C3C;
        data  = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                data  = 32'h1234_5678;
                valid = 1'b1;
            end
            check_bit("hold1", k, w);
            tick();
        end
        valid = 1'b0;
        chk("hold rx1", 64'(rx_word), 64'(32'h0F0F_3C3C));
        for (int k = 0; k < 32; k++) begin
            check_bit("hold2", k, 32'h1234_5678);
            data = data ^ 32'hFFFF_0000;
            tick();
        end
        check_idle("hold");
        chk("hold rx2", 64'(rx_word), 64'(32'h1234_5678));

        // Asynchronous reset mid-cycle at bit 15.
        data  = 32'hFFFF_FFFF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_bit("prerst", k, 32'hFFFF_FFFF);
            if (k < 15) begin
                tick();
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst sdo", 64'(sdo), 64'(1'b0));
        chk("arst svalid", 64'(svalid), 64'(1'b0));
        chk("arst busy", 64'(busy), 64'(1'b0));
        chk("arst done", 64'(done), 64'(1'b0));
        chk("arst ready", 64'(ready), 64'(1'b0));
        data  = 32'h0000_0003;
        valid = 1'b1;
        tick();
        chk("inrst svalid", 64'(svalid), 64'(1'b0));
        chk("inrst busy", 64'(busy), 64'(1'b0));
        chk("inrst done", 64'(done), 64'(1'b0));
        chk("inrst ready", 64'(ready), 64'(1'b0));
        rst = 1'b0;
        #1;
        chk("rel ready", 64'(ready), 64'(1'b1));
        tick();
        valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_bit("after-rst", k, 32'h0000_0003);
            tick();
        end
        check_idle("after-rst");
        chk("after-rst rx", 64'(rx_word), 64'(32'h0000_0003));

        // Input toggles after acceptance do not disturb the frame.
        data  = 32'hDEAD_BEEF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_bit("toggle", k, 32'hDEAD_BEEF);
            data = $urandom;
            tick();
        end
        check_idle("toggle");
        chk("toggle rx", 64'(rx_word), 64'(32'hDEAD_BEEF));

        // 8-bit instance with idle level 1.
        chk("w8 idle sdo", 64'(sdo8), 64'(1'b1));
        chk("w8 idle ready", 64'(ready8), 64'(1'b1));
        data8  = 8'h00;
        valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        data8  = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("w8 sdo k=%0d", k), 64'(sdo8), 64'(1'b0));
            chk($sformatf("w8 svalid k=%0d", k), 64'(svalid8), 64'(1'b1));
            chk($sformatf("w8 busy k=%0d", k), 64'(busy8), 64'(1'b1));
            chk($sformatf("w8 done k=%0d", k), 64'(done8), 64'(k == 7));
            tick();
        end
        chk("w8 end sdo", 64'(sdo8), 64'(1'b1));
        chk("w8 end svalid", 64'(svalid8), 64'(1'b0));
        chk("w8 end busy", 64'(busy8), 64'(1'b0));
        chk("w8 end done", 64'(done8), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_piso_serializer_32
